imem_load_ctrl: RTL

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

---
 rtl/imem_load_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: receives program bytes from a serial-to-parallel source and
// writes them into instruction memory. The RISC-V core is held in reset until
// the load completes.
// Optional feature: define LOAD_CHECKSUM_EN to keep an XOR checksum and accept a
// trailer byte that must match it. When the macro is undefined, err is tied to 0.
module imem_load_ctrl #(
    parameter int unsigned    m         = 32,
    parameter logic [m-1:0]   BASE_ADDR = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [m-1:0] len_bytes,
    input  logic         d_valid,
    input  logic [7:0]   data_in,
    output logic         w_en_to_imem,
    output logic         grant,
    output logic [7:0]   out_data_imem,
    output logic [m-1:0] to_imem_addr,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cpu_rst
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, GAP, DONE, ERR} state_t;

    state_t       state;
    logic [m-1:0] remaining;

`ifdef LOAD_CHECKSUM_EN
    logic [7:0] checksum;
    logic       trailer;
    logic       trailer_ok;

    // Load sequencer with checksum trailer; every output is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            remaining     <= '0;
            checksum      <= '0;
            trailer       <= 1'b0;
            trailer_ok    <= 1'b0;
            w_en_to_imem  <= 1'b0;
            grant         <= 1'b0;
            out_data_imem <= '0;
            to_imem_addr  <= BASE_ADDR;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            cpu_rst       <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        remaining    <= len_bytes;
                        to_imem_addr <= BASE_ADDR;
                        checksum     <= '0;
                        // An empty payload goes straight to the trailer byte.
                        trailer      <= (len_bytes == '0);
                        done         <= 1'b0;
                        err          <= 1'b0;
                        cpu_rst      <= 1'b1;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (d_valid) begin
                        out_data_imem <= data_in;
                        w_en_to_imem  <= ~trailer;
                        grant         <= 1'b1;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    w_en_to_imem <= 1'b0;
                    grant        <= 1'b0;
                    state        <= GAP;
                    if (trailer) begin
                        trailer_ok <= (out_data_imem == checksum);
                    end else begin
                        to_imem_addr <= to_imem_addr + m'(1);
                        remaining    <= remaining - m'(1);
                        checksum     <= checksum ^ out_data_imem;
                    end
                end
                GAP: begin
                    if (!d_valid) begin
                        if (trailer) begin
                            busy <= 1'b0;
                            if (trailer_ok) begin
                                done    <= 1'b1;
                                cpu_rst <= 1'b0;
                                state   <= DONE;
                            end else begin
                                err   <= 1'b1;
                                state <= ERR;
                            end
                        end else begin
                            trailer <= (remaining == '0);
                            state   <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign err = 1'b0;

    // Load sequencer without checksum; every output is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            remaining     <= '0;
            w_en_to_imem  <= 1'b0;
            grant         <= 1'b0;
            out_data_imem <= '0;
            to_imem_addr  <= BASE_ADDR;
            busy          <= 1'b0;
            done          <= 1'b0;
            cpu_rst       <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        remaining    <= len_bytes;
                        to_imem_addr <= BASE_ADDR;
                        if (len_bytes == '0) begin
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                            busy    <= 1'b0;
                            state   <= DONE;
                        end else begin
                            done    <= 1'b0;
                            cpu_rst <= 1'b1;
                            busy    <= 1'b1;
                            state   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (d_valid) begin
                        out_data_imem <= data_in;
                        w_en_to_imem  <= 1'b1;
                        grant         <= 1'b1;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    w_en_to_imem <= 1'b0;
                    grant        <= 1'b0;
                    to_imem_addr <= to_imem_addr + m'(1);
                    remaining    <= remaining - m'(1);
                    state        <= GAP;
                end
                GAP: begin
                    // Wait for the source to drop d_valid so a held byte is written once.
                    if (!d_valid) begin
                        if (remaining == '0) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                            state   <= DONE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule
